// File: rtl/char_glyph_blitter_pkg.sv
// Shared text-display package: glyph geometry, screen geometry, the
// "character slot out of range" sentinel address, bus widths and the
// glyph-blitter FSM state encoding. Used by the address-mapping stage and
// by char_glyph_blitter.
package char_glyph_blitter_pkg;

    localparam int DEF_CHAR_WIDTH    = 20;
    localparam int DEF_CHAR_HEIGHT   = 30;
    localparam int DEF_SCREEN_WIDTH  = 680;
    localparam int DEF_NUM_GLYPHS    = 128;
    localparam int DEF_SENTINEL_ADDR = 240 * 680;

    localparam int FB_ADDR_W  = 19;
    localparam int ROM_ADDR_W = 13;
    localparam int PIX_W      = 8;

    // Blitter FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Map one glyph bit to a framebuffer pixel value
    function automatic logic [PIX_W-1:0] pixel_value(
        input logic             bit_set,
        input logic [PIX_W-1:0] fg,
        input logic [PIX_W-1:0] bg
    );
        return bit_set ? fg : bg;
    endfunction

endpackage

// File: rtl/char_glyph_blitter.sv
// char_glyph_blitter: draws one CHAR_WIDTH x CHAR_HEIGHT glyph from an
// external synchronous glyph ROM into a linear framebuffer, one pixel per
// clock.
//
// Ports:
//   clock          - sole clock, posedge
//   reset          - synchronous, active-high
//   start          - draw request, sampled only while idle
//   char_code      - glyph index
//   base_address   - framebuffer address of the glyph's top-left pixel
//   glyph_rom_addr - ROM row address (char_code*CHAR_HEIGHT + row)
//   glyph_rom_data - ROM row bitmap, MSB = leftmost pixel, valid one cycle
//                    after glyph_rom_addr
//   fb_addr/fb_data/fb_we - framebuffer write port
//   busy           - high whenever not idle
//   done           - one-cycle pulse at completion
//
// All outputs are registered: the next-state logic computes the following
// cycle's state and the output registers are loaded from those values.
module char_glyph_blitter
    import char_glyph_blitter_pkg::*;
#(
    parameter int         CHAR_WIDTH    = DEF_CHAR_WIDTH,
    parameter int         CHAR_HEIGHT   = DEF_CHAR_HEIGHT,
    parameter int         SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int         NUM_GLYPHS    = DEF_NUM_GLYPHS,
    parameter logic [7:0] FG_COLOR      = 8'hFF,
    parameter logic [7:0] BG_COLOR      = 8'h00,
    parameter int         SENTINEL_ADDR = DEF_SENTINEL_ADDR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            char_code,
    input  logic [18:0]           base_address,
    output logic [12:0]           glyph_rom_addr,
    input  logic [CHAR_WIDTH-1:0] glyph_rom_data,
    output logic [18:0]           fb_addr,
    output logic [7:0]            fb_data,
    output logic                  fb_we,
    output logic                  busy,
    output logic                  done
);

    localparam int COL_W = (CHAR_WIDTH  > 1) ? $clog2(CHAR_WIDTH)  : 1;
    localparam int ROW_W = (CHAR_HEIGHT > 1) ? $clog2(CHAR_HEIGHT) : 1;

    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(CHAR_WIDTH - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(CHAR_HEIGHT - 1);
    localparam logic [FB_ADDR_W-1:0]  LINE_STEP = FB_ADDR_W'(SCREEN_WIDTH);
    localparam logic [FB_ADDR_W-1:0]  SENTINEL  = FB_ADDR_W'(SENTINEL_ADDR);
    localparam logic [ROM_ADDR_W-1:0] ROM_ROWS  = ROM_ADDR_W'(CHAR_HEIGHT);

    logic [2:0]            state_r,      state_s;
    logic [ROW_W-1:0]      row_r,        row_s;
    logic [COL_W-1:0]      col_r,        col_s;
    logic [FB_ADDR_W-1:0]  row_base_r,   row_base_s;
    logic [CHAR_WIDTH-1:0] shift_r,      shift_s;
    logic [ROM_ADDR_W-1:0] glyph_base_r, glyph_base_s;
    logic                  sentinel_r,   sentinel_s;
    logic                  blank_r,      blank_s;

    logic [ROM_ADDR_W-1:0] rom_addr_r;
    logic [FB_ADDR_W-1:0]  fb_addr_r;
    logic [PIX_W-1:0]      fb_data_r;
    logic                  fb_we_r;
    logic                  busy_r;
    logic                  done_r;

    assign glyph_rom_addr = rom_addr_r;
    assign fb_addr        = fb_addr_r;
    assign fb_data        = fb_data_r;
    assign fb_we          = fb_we_r;
    assign busy           = busy_r;
    assign done           = done_r;

    // Next-state and datapath-update logic for the blitter FSM
    always_comb begin
        state_s      = state_r;
        row_s        = row_r;
        col_s        = col_r;
        row_base_s   = row_base_r;
        shift_s      = shift_r;
        glyph_base_s = glyph_base_r;
        sentinel_s   = sentinel_r;
        blank_s      = blank_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    row_s      = '0;
                    col_s      = '0;
                    row_base_s = base_address;
                    sentinel_s = (base_address == SENTINEL);
                    blank_s    = (int'(char_code) >= NUM_GLYPHS);
                    // Out-of-range codes park the ROM on glyph 0; the data
                    // is discarded in LATCH so every pixel draws as BG.
                    if (blank_s) begin
                        glyph_base_s = '0;
                    end else begin
                        glyph_base_s = ROM_ADDR_W'(char_code) * ROM_ROWS;
                    end
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // A sentinel request spends this one cycle and then finishes
                // without ever entering DRAW.
                if (sentinel_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (blank_r) begin
                    shift_s = '0;
                end else begin
                    shift_s = glyph_rom_data;
                end
                col_s   = '0;
                state_s = ST_DRAW;
            end
            ST_DRAW: begin
                if (col_r == LAST_COL) begin
                    if (row_r == LAST_ROW) begin
                        state_s = ST_DONE;
                    end else begin
                        row_s      = row_r + ROW_W'(1);
                        col_s      = '0;
                        row_base_s = row_base_r + LINE_STEP;
                        state_s    = ST_FETCH;
                    end
                end else begin
                    // MSB of the shift register is always the current pixel
                    col_s   = col_r + COL_W'(1);
                    shift_s = {shift_r[CHAR_WIDTH-2:0], 1'b0};
                    state_s = ST_DRAW;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered-output update with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            row_r        <= '0;
            col_r        <= '0;
            row_base_r   <= '0;
            shift_r      <= '0;
            glyph_base_r <= '0;
            sentinel_r   <= 1'b0;
            blank_r      <= 1'b0;
            rom_addr_r   <= '0;
            fb_addr_r    <= '0;
            fb_data_r    <= '0;
            fb_we_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            row_r        <= row_s;
            col_r        <= col_s;
            row_base_r   <= row_base_s;
            shift_r      <= shift_s;
            glyph_base_r <= glyph_base_s;
            sentinel_r   <= sentinel_s;
            blank_r      <= blank_s;
            fb_we_r      <= (state_s == ST_DRAW);
            fb_addr_r    <= row_base_s + FB_ADDR_W'(col_s);
            fb_data_r    <= pixel_value(shift_s[CHAR_WIDTH-1], FG_COLOR, BG_COLOR);
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
            if (state_s == ST_FETCH) begin
                rom_addr_r <= glyph_base_s + ROM_ADDR_W'(row_s);
            end else begin
                rom_addr_r <= rom_addr_r;
            end
        end
    end

endmodule

// File: tb/tb_char_glyph_blitter.sv
// Directed self-checking bench for char_glyph_blitter with default
// parameters. A synchronous ROM model supplies glyph rows; a write monitor
// compares every framebuffer write against an address/pixel model and
// summarises what it saw for the directed checks in the main sequence.
module tb_char_glyph_blitter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  char_code = 8'd0;
    logic [18:0] base_address = 19'd0;
    logic [12:0] glyph_rom_addr;
    logic [19:0] glyph_rom_data = 20'd0;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    char_glyph_blitter dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .char_code      (char_code),
        .base_address   (base_address),
        .glyph_rom_addr (glyph_rom_addr),
        .glyph_rom_data (glyph_rom_data),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .fb_we          (fb_we),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    // Glyph ROM content: row 0 of every glyph is 20'h80001, other rows a
    // pattern derived from the address.
    function automatic logic [19:0] rom_fn(input logic [12:0] a);
        if (a % 13'd30 == 13'd0) return 20'h80001;
        else return {a[9:0] ^ 10'h2A5, a[9:0]};
    endfunction

    function automatic logic [7:0] exp_pixel(input int code, input logic blank,
                                             input int row, input int col);
        logic [19:0] r;
        if (blank) return 8'h00;
        r = rom_fn(13'(code * 30 + row));
        return r[19 - col] ? 8'hFF : 8'h00;
    endfunction

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge clock) glyph_rom_data <= rom_fn(glyph_rom_addr);

    // Expectations for the monitor, written only by the main sequence
    int   mon_code  = 0;
    int   mon_base  = 0;
    logic mon_blank = 1'b0;
    logic mon_clr   = 1'b0;

    // Monitor state, written only by the monitor
    int mon_row = 0, mon_col = 0, wr_count = 0, pix_err = 0, fg_count = 0;
    int rom_oob = 0, first_addr = -1, last_addr = -1;
    logic [7:0] px0 = 8'd0, px1 = 8'd0, px19 = 8'd0;

    // Write monitor: models row/col progression and checks each write
    always @(negedge clock) begin
        if (mon_clr) begin
            mon_row <= 0; mon_col <= 0; wr_count <= 0; pix_err <= 0;
            fg_count <= 0; rom_oob <= 0; first_addr <= -1; last_addr <= -1;
        end else begin
            if (fb_we === 1'b1) begin
                if (int'(fb_addr) !== mon_base + mon_row * 680 + mon_col ||
                    fb_data !== exp_pixel(mon_code, mon_blank, mon_row, mon_col))
                    pix_err <= pix_err + 1;
                if (wr_count == 0) begin first_addr <= int'(fb_addr); px0 <= fb_data; end
                if (wr_count == 1)  px1  <= fb_data;
                if (wr_count == 19) px19 <= fb_data;
                if (fb_data == 8'hFF) fg_count <= fg_count + 1;
                last_addr <= int'(fb_addr);
                wr_count  <= wr_count + 1;
                if (mon_col == 19) begin
                    mon_col <= 0;
                    mon_row <= mon_row + 1;
                end else begin
                    mon_col <= mon_col + 1;
                end
            end
            if (glyph_rom_addr >= 13'd3840) rom_oob <= rom_oob + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic arm_monitor(input int code, input int base);
        mon_code  = code;
        mon_base  = base;
        mon_blank = (code >= 128);
        mon_clr   = 1'b1;
        @(negedge clock);
        #1 mon_clr = 1'b0;
    endtask

    // Issue one request; done_cyc is the cycle done is seen, counting the
    // cycle in which start is sampled as cycle 0 (0 = never seen).
    task automatic run_req(input int code, input int base, input logic restart,
                           output int done_cyc, output logic done_after,
                           output logic busy_after);
        int k;
        arm_monitor(code, base);
        @(negedge clock);
        start = 1'b1; char_code = 8'(code); base_address = 19'(base);
        @(posedge clock);
        #1 start = 1'b0;
        k = 0; done_cyc = 0;
        while (done_cyc == 0 && k < 2000) begin
            @(posedge clock);
            #1 k++;
            if (restart && k == 100) begin
                start = 1'b1; char_code = 8'h10; base_address = 19'd0;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) done_cyc = k + 1;
        end
        @(posedge clock);
        #1 done_after = done; busy_after = busy;
    endtask

    initial begin
        int   dc;
        logic da, ba;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_rom_addr", int'(glyph_rom_addr), 0);
        @(negedge clock) reset = 1'b0;

        // Full glyph 'A' at line 120 (away from the sentinel address)
        run_req(8'h41, 81600, 1'b0, dc, da, ba);
        chk("a_done_cycle", dc, 661);
        chk("a_writes", wr_count, 600);
        chk("a_first_addr", first_addr, 81600);
        chk("a_last_addr", last_addr, 101339);
        chk("a_pixel_errs", pix_err, 0);
        chk("a_px0_fg", int'(px0), 255);
        chk("a_px1_bg", int'(px1), 0);
        chk("a_px19_fg", int'(px19), 255);
        chk("a_done_width", int'(da), 0);
        chk("a_idle_after", int'(ba), 0);

        // Sentinel base: no writes, done two cycles after start
        run_req(8'h41, 163200, 1'b0, dc, da, ba);
        chk("sent_done_cycle", dc, 2);
        chk("sent_writes", wr_count, 0);
        chk("sent_idle_after", int'(ba), 0);

        // Out-of-range glyph: full-size background block, ROM kept in range
        run_req(200, 13600, 1'b0, dc, da, ba);
        chk("oor_done_cycle", dc, 661);
        chk("oor_writes", wr_count, 600);
        chk("oor_fg_pixels", fg_count, 0);
        chk("oor_pixel_errs", pix_err, 0);
        chk("oor_rom_range", rom_oob, 0);

        // Reset in the middle of a draw
        arm_monitor(8'h22, 40800);
        @(negedge clock);
        start = 1'b1; char_code = 8'h22; base_address = 19'd40800;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (299) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_fb_we", int'(fb_we), 0);
        chk("mid_rst_rom_addr", int'(glyph_rom_addr), 0);
        chk("mid_rst_pixel_errs", pix_err, 0);
        @(negedge clock) reset = 1'b0;

        // Fresh draw at base 0 after the abort
        run_req(8'h05, 0, 1'b0, dc, da, ba);
        chk("b0_done_cycle", dc, 661);
        chk("b0_writes", wr_count, 600);
        chk("b0_first_addr", first_addr, 0);
        chk("b0_last_addr", last_addr, 19739);
        chk("b0_pixel_errs", pix_err, 0);

        // Second start and input changes while busy are ignored
        run_req(8'h30, 6800, 1'b1, dc, da, ba);
        chk("rs_done_cycle", dc, 661);
        chk("rs_writes", wr_count, 600);
        chk("rs_first_addr", first_addr, 6800);
        chk("rs_last_addr", last_addr, 26539);
        chk("rs_pixel_errs", pix_err, 0);
        chk("rs_idle_after", int'(ba), 0);

        // Start coincident with reset is ignored
        @(negedge clock);
        reset = 1'b1; start = 1'b1; char_code = 8'h41; base_address = 19'd0;
        @(posedge clock);
        #1 chk("rst_start_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        @(posedge clock);
        #1 chk("rst_start_still_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
